// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared state type, default widths and counter sizing for product_accumulator
package product_acc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } acc_state_t;

   localparam int PROD_W_DEF = 8;
   localparam int ACC_W_DEF  = 10;

   // Counter must reach N_TERMS itself, not just N_TERMS-1.
   function automatic int cnt_width(input int n_terms);
      return $clog2(n_terms + 1);
   endfunction

endpackage

// File: rtl/acc_adder.sv
// rtl/acc_adder.sv - combinational accumulator adder with carry-out; PRODUCT_ACC_SATURATE_EN clamps on carry
module acc_adder #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 10
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] product,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] full;

   assign full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
   assign ovf  = full[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
   // Once clamped, any further term carries again (or adds zero), so the clamp holds.
   assign sum = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
   assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums N_TERMS products per operation over valid/ready; see acc_adder for PRODUCT_ACC_SATURATE_EN
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter int PROD_W  = PROD_W_DEF,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic              busy
);

   localparam int CW = cnt_width(N_TERMS);

   acc_state_t      state;
   logic [CW-1:0]   count;
   logic [ACC_W-1:0] sum;
   logic            sum_ovf;

   acc_adder #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_adder (
      .acc     (acc_out),
      .product (product),
      .sum     (sum),
      .ovf     (sum_ovf)
   );

   // Handshake flags are registered alongside the state they decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc_out   <= '0;
         overflow  <= 1'b0;
         count     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc_out  <= '0;
                  overflow <= 1'b0;
                  count    <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid && in_ready) begin
                  acc_out  <= sum;
                  overflow <= overflow | sum_ovf;
                  count    <= count + CW'(1);
                  if (count == CW'(N_TERMS - 1)) begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     acc_out  <= '0;
                     overflow <= 1'b0;
                     count    <= '0;
                     in_ready <= 1'b1;
                     state    <= ACCUM;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized self-checking bench for product_accumulator (default and ACC_W=8/N_TERMS=2 instances)
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       st   [2];
   logic       iv   [2];
   logic [7:0] prd  [2];
   logic       ordy [2];

   logic       ir0, ov0, of0, bz0;
   logic [9:0] acc0;
   logic       ir1, ov1, of1, bz1;
   logic [7:0] acc1;

   int checks = 0;
   int errors = 0;
   int unsigned pq[$];
   int chained[2];

   product_accumulator #(.PROD_W(8), .N_TERMS(4), .ACC_W(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(iv[0]), .in_ready(ir0),
      .product(prd[0]), .out_valid(ov0), .out_ready(ordy[0]), .acc_out(acc0),
      .overflow(of0), .busy(bz0)
   );

   product_accumulator #(.PROD_W(8), .N_TERMS(2), .ACC_W(8)) u_small (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(iv[1]), .in_ready(ir1),
      .product(prd[1]), .out_valid(ov1), .out_ready(ordy[1]), .acc_out(acc1),
      .overflow(of1), .busy(bz1)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned g_acc(input int w);
      return (w != 0) ? 32'(acc1) : 32'(acc0);
   endfunction
   function automatic int unsigned g_ir(input int w);
      return (w != 0) ? 32'(ir1) : 32'(ir0);
   endfunction
   function automatic int unsigned g_ov(input int w);
      return (w != 0) ? 32'(ov1) : 32'(ov0);
   endfunction
   function automatic int unsigned g_of(input int w);
      return (w != 0) ? 32'(of1) : 32'(of0);
   endfunction
   function automatic int unsigned g_bz(input int w);
      return (w != 0) ? 32'(bz1) : 32'(bz0);
   endfunction

   // Reference: true sum of the accepted terms, then wrap or clamp to the accumulator width.
   function automatic int unsigned model_acc(input int unsigned total, input int accw);
      int unsigned lim;
      lim = (32'd1 << accw);
`ifdef PRODUCT_ACC_SATURATE_EN
      return (total >= lim) ? lim - 1 : total;
`else
      return total % lim;
`endif
   endfunction

   task automatic begin_op(input int w);
      st[w] = 1'b1;
      tick();
      st[w] = 1'b0;
      check("start_in_ready", g_ir(w), 1);
      check("start_busy", g_bz(w), 1);
      check("start_acc_clear", g_acc(w), 0);
      check("start_ovf_clear", g_of(w), 0);
   endtask

   // Feeds pq into the instance, then holds DONE for bp cycles while in_valid is asserted.
   task automatic run_op(input int w, input int fixgap, input int bp);
      int unsigned total;
      int accw;
      int n;
      int gap;
      int unsigned held;
      accw  = (w != 0) ? 8 : 10;
      n     = pq.size();
      total = 0;
      for (int i = 0; i < n; i++) begin
         check("term_in_ready", g_ir(w), 1);
         check("term_no_early_valid", g_ov(w), 0);
         iv[w]  = 1'b1;
         prd[w] = 8'(pq[i]);
         total += pq[i];
         tick();
         iv[w]  = 1'b0;
         prd[w] = 8'($urandom_range(0, 255));
         if (i < n - 1) begin
            gap = (fixgap >= 0) ? fixgap : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
               st[w] = 1'($urandom_range(0, 1));
               tick();
               st[w] = 1'b0;
               check("gap_in_ready", g_ir(w), 1);
               check("gap_acc_hold", g_acc(w), model_acc(total, accw));
            end
         end
      end
      check("done_latency", g_ov(w), 1);
      check("done_in_ready", g_ir(w), 0);
      check("result_acc", g_acc(w), model_acc(total, accw));
      check("result_ovf", g_of(w), (total >= (32'd1 << accw)) ? 1 : 0);
      held = g_acc(w);
      for (int b = 0; b < bp; b++) begin
         iv[w]  = 1'b1;
         prd[w] = 8'($urandom_range(1, 255));
         st[w]  = 1'($urandom_range(0, 1));
         tick();
         check("bp_valid", g_ov(w), 1);
         check("bp_acc_stable", g_acc(w), held);
         check("bp_in_ready", g_ir(w), 0);
      end
      iv[w] = 1'b0;
      st[w] = 1'b0;
   endtask

   task automatic finish_op(input int w, input int nxt);
      ordy[w] = 1'b1;
      st[w]   = 1'(nxt);
      tick();
      ordy[w] = 1'b0;
      st[w]   = 1'b0;
      check("release_valid", g_ov(w), 0);
      check("release_busy", g_bz(w), nxt);
      check("release_in_ready", g_ir(w), nxt);
      if (nxt != 0) check("b2b_acc_clear", g_acc(w), 0);
   endtask

   initial begin
      int w;
      for (int k = 0; k < 2; k++) begin
         st[k] = 1'b0; iv[k] = 1'b0; prd[k] = 8'd0; ordy[k] = 1'b0; chained[k] = 0;
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("rst_acc", acc0, 0);
      check("rst_valid", ov0, 0);
      check("rst_in_ready", ir0, 0);
      check("rst_busy", bz0, 0);
      check("rst_ovf", of0, 0);

      iv[0] = 1'b1; prd[0] = 8'd50;
      repeat (3) tick();
      check("idle_acc", acc0, 0);
      check("idle_in_ready", ir0, 0);
      check("idle_busy", bz0, 0);
      iv[0] = 1'b0;

      begin_op(0);
      pq = '{225, 225, 225, 225};
      run_op(0, 0, 0);
      check("fullscale_900", acc0, 900);
      finish_op(0, 0);

      begin_op(0);
      pq = '{1, 2, 3, 4};
      run_op(0, 2, 5);
      check("gaps_10", acc0, 10);
      finish_op(0, 1);
      pq = '{7, 7, 7, 7};
      run_op(0, 0, 0);
      check("b2b_28", acc0, 28);
      finish_op(0, 0);

      begin_op(1);
      pq = '{225, 225};
      run_op(1, 0, 1);
`ifdef PRODUCT_ACC_SATURATE_EN
      check("small_sat_255", acc1, 255);
`else
      check("small_wrap_194", acc1, 194);
`endif
      check("small_ovf", of1, 1);
      finish_op(1, 0);

      begin_op(0);
      iv[0] = 1'b1; prd[0] = 8'd100;
      repeat (2) tick();
      iv[0] = 1'b0;
      check("pre_reset_acc", acc0, 200);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_acc", acc0, 0);
      check("async_rst_in_ready", ir0, 0);
      check("async_rst_busy", bz0, 0);
      check("async_rst_valid", ov0, 0);
      #1 rst_n = 1'b1;
      tick();
      begin_op(0);
      pq = '{5, 5, 5, 5};
      run_op(0, -1, 0);
      check("post_reset_20", acc0, 20);
      finish_op(0, 0);

      for (int it = 0; it < 40; it++) begin
         w = int'($urandom_range(0, 1));
         pq.delete();
         for (int t = 0; t < ((w != 0) ? 2 : 4); t++) pq.push_back($urandom_range(0, 255));
         if (chained[w] == 0) begin_op(w);
         run_op(w, -1, int'($urandom_range(0, 3)));
         chained[w] = int'($urandom_range(0, 1));
         finish_op(w, chained[w]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
